// File: rtl/coeff_pkg.sv
// Shared definitions for the twiddle coefficient loader and sequencer:
// FSM states, default geometry and the packed-table entry offset.
package coeff_pkg;

  localparam int unsigned DEF_NBITS = 2;
  localparam int unsigned DEF_N     = 8;
  localparam int unsigned COEFF_W   = DEF_NBITS * 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    COMMIT = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Entry k sits at the MSB end for k=0; returns the LSB position of entry k.
  function automatic int unsigned entry_lsb(input int unsigned k,
                                            input int unsigned n,
                                            input int unsigned cw);
    return (n - 1 - k) * cw;
  endfunction

endpackage

// File: rtl/coeff_bank.sv
// Packed coefficient register bank with a single indexed write port.
// Entry 0 occupies the MSBs, matching the sequencer's read packing.
module coeff_bank
  import coeff_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS,
  parameter int unsigned N     = DEF_N,
  localparam int unsigned CW   = NBITS * 2,
  localparam int unsigned TW   = NBITS * N * 2,
  localparam int unsigned IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] index,
  input  logic [CW-1:0] wdata,
  output logic [TW-1:0] bank
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank <= '0;
    end else if (we) begin
      bank[entry_lsb(32'(index), N, CW) +: CW] <= wdata;
    end
  end

endmodule

// File: rtl/coeff_table_loader.sv
// Loads a frame of twiddle coefficients into a shadow bank and commits it
// atomically to the active table only when the frame length is exactly N.
module coeff_table_loader
  import coeff_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS,
  parameter int unsigned N     = DEF_N,
  localparam int unsigned CW   = NBITS * 2,
  localparam int unsigned TW   = NBITS * N * 2,
  localparam int unsigned IW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [CW-1:0] s_data,
  input  logic          s_last,
  output logic [TW-1:0] coeff_table,
  output logic          table_valid,
  output logic          load_done,
  output logic          err_short,
  output logic          err_long
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        state;
  logic [IW-1:0] index;
  logic [TW-1:0] shadow;
  logic          accept_c;
  logic          bank_we_c;

  assign accept_c  = s_valid & s_ready;
  assign bank_we_c = accept_c & (state == LOAD);

  coeff_bank #(
    .NBITS (NBITS),
    .N     (N)
  ) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we_c),
    .index (index),
    .wdata (s_data),
    .bank  (shadow)
  );

  // Frame-length FSM; s_ready is registered and low only while in COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      index       <= '0;
      s_ready     <= 1'b1;
      coeff_table <= '0;
      table_valid <= 1'b0;
      load_done   <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        LOAD: begin
          if (accept_c) begin
            if (s_last) begin
              index <= '0;
              if (index == LAST_IDX) begin
                state   <= COMMIT;
                s_ready <= 1'b0;
              end else begin
                err_short <= 1'b1;
              end
            end else if (index == LAST_IDX) begin
              index    <= '0;
              err_long <= 1'b1;
              state    <= DRAIN;
            end else begin
              index <= index + IW'(1);
            end
          end
        end
        COMMIT: begin
          coeff_table <= shadow;
          table_valid <= 1'b1;
          load_done   <= 1'b1;
          index       <= '0;
          s_ready     <= 1'b1;
          state       <= LOAD;
        end
        DRAIN: begin
          // Overlong frame: swallow beats silently up to its s_last.
          if (accept_c && s_last) begin
            state <= LOAD;
          end
        end
        default: begin
          index   <= '0;
          s_ready <= 1'b1;
          state   <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_table_loader.sv
// Self-checking bench for coeff_table_loader (NBITS=2, N=8): vector table,
// hand-written corner sequences and a randomized stream against a frame model.
module tb_coeff_table_loader;

  localparam int unsigned NB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_data;
  logic        s_last;
  logic [31:0] coeff_table;
  logic        table_valid;
  logic        load_done;
  logic        err_short;
  logic        err_long;

  coeff_table_loader #(.NBITS(2), .N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .coeff_table (coeff_table),
    .table_valid (table_valid),
    .load_done   (load_done),
    .err_short   (err_short),
    .err_long    (err_long)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int n_done = 0, n_short = 0, n_long = 0, n_rdy_low = 0;
  bit count_rdy = 1'b0;
  logic [31:0] commit_q[$];

  // Pulse and commit observers, sampled away from the active edge.
  always @(negedge clk) begin
    if (load_done) begin
      n_done++;
      commit_q.push_back(coeff_table);
    end
    if (err_short) n_short++;
    if (err_long)  n_long++;
    if (count_rdy && !s_ready) n_rdy_low++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [3:0] d, input logic l);
    int guard;
    guard = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] w, input int nbeats, input bit with_last);
    for (int i = 0; i < nbeats; i++)
      send_beat(4'(w >> (28 - 4 * i)), with_last && (i == nbeats - 1));
  endtask

  task automatic rand_gap();
    int g;
    g = $urandom_range(0, 3);
    if (g > 0) idle(g - 1);
  endtask

  // Frame-level reference: a frame commits only if s_last lands exactly on beat N.
  logic [3:0]  m_cur[$];
  bit          m_drain;
  logic [31:0] m_commits[$];
  int          m_short, m_long;

  task automatic model_beat(input logic [3:0] d, input logic l);
    logic [31:0] t;
    if (m_drain) begin
      if (l) m_drain = 1'b0;
      return;
    end
    m_cur.push_back(d);
    if (l) begin
      if (m_cur.size() == NB) begin
        t = '0;
        foreach (m_cur[k]) t = (t << 4) | 32'(m_cur[k]);
        m_commits.push_back(t);
      end else begin
        m_short++;
      end
      m_cur.delete();
    end else if (m_cur.size() == NB) begin
      m_long++;
      m_drain = 1'b1;
      m_cur.delete();
    end
  endtask

  typedef struct {
    int          nbeats;
    logic [31:0] word;
    bit          last;
    logic [31:0] exp_table;
    int          exp_done;
    int          exp_short;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_done, b_short, b_long;
    logic [31:0] exp_tab;

    vecs[0] = '{8, 32'h12345678, 1'b1, 32'h12345678, 1, 0};
    vecs[1] = '{5, 32'hFFFFF000, 1'b1, 32'h12345678, 0, 1};
    vecs[2] = '{8, 32'hABCDEF01, 1'b1, 32'hABCDEF01, 1, 0};
    vecs[3] = '{1, 32'h90000000, 1'b1, 32'hABCDEF01, 0, 1};
    vecs[4] = '{7, 32'h7777777F, 1'b1, 32'hABCDEF01, 0, 1};
    vecs[5] = '{8, 32'h00000000, 1'b1, 32'h00000000, 1, 0};
    vecs[6] = '{8, 32'hFEDCBA98, 1'b1, 32'hFEDCBA98, 1, 0};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_table", coeff_table, 32'h0);
    check("rst_valid", 32'(table_valid), 32'd0);
    check("rst_pulses", {29'd0, load_done, err_short, err_long}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(s_ready), 32'd1);

    // Vector table: frame outcome, table and sticky valid after each frame.
    for (int i = 0; i < 7; i++) begin
      b_done = n_done; b_short = n_short; b_long = n_long;
      send_frame(vecs[i].word, vecs[i].nbeats, vecs[i].last);
      idle(3);
      check($sformatf("v%0d_table", i), coeff_table, vecs[i].exp_table);
      check($sformatf("v%0d_valid", i), 32'(table_valid), 32'd1);
      check($sformatf("v%0d_done", i), 32'(n_done - b_done), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_short", i), 32'(n_short - b_short), 32'(vecs[i].exp_short));
      check($sformatf("v%0d_long", i), 32'(n_long - b_long), 32'd0);
    end

    // Commit latency: COMMIT cycle after last beat, table and pulse one edge later.
    send_frame(32'h13579BDF, 8, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("lat_done_early", 32'(load_done), 32'd0);
    check("lat_ready_commit", 32'(s_ready), 32'd0);
    check("lat_table_early", coeff_table, 32'hFEDCBA98);
    @(negedge clk);
    check("lat_done", 32'(load_done), 32'd1);
    check("lat_table", coeff_table, 32'h13579BDF);
    check("lat_ready_back", 32'(s_ready), 32'd1);
    @(negedge clk);
    check("lat_done_1cyc", 32'(load_done), 32'd0);

    // Short-frame pulse timing.
    send_frame(32'h22200000, 3, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("short_pulse", 32'(err_short), 32'd1);
    @(negedge clk);
    check("short_pulse_1cyc", 32'(err_short), 32'd0);

    // Overlong frame then drain of three beats.
    b_done = n_done; b_short = n_short; b_long = n_long;
    send_frame(32'h11111111, 8, 1'b0);
    @(negedge clk);
    check("long_pulse", 32'(err_long), 32'd1);
    count_rdy = 1'b1;
    send_frame(32'h44400000, 3, 1'b1);
    idle(3);
    count_rdy = 1'b0;
    check("drain_ready", 32'(n_rdy_low), 32'd0);
    check("drain_long_cnt", 32'(n_long - b_long), 32'd1);
    check("drain_short_cnt", 32'(n_short - b_short), 32'd0);
    check("drain_done_cnt", 32'(n_done - b_done), 32'd0);
    check("drain_table", coeff_table, 32'h13579BDF);
    send_frame(32'h55667788, 8, 1'b1);
    idle(3);
    check("after_drain_table", coeff_table, 32'h55667788);

    // Back-to-back frames with s_valid held high.
    commit_q.delete();
    n_rdy_low = 0;
    count_rdy = 1'b1;
    send_frame(32'hC0FFEE12, 8, 1'b1);
    send_frame(32'h3456789A, 8, 1'b1);
    idle(3);
    count_rdy = 1'b0;
    check("b2b_ready_low", 32'(n_rdy_low), 32'd2);
    check("b2b_commits", 32'(commit_q.size()), 32'd2);
    if (commit_q.size() == 2) begin
      check("b2b_first", commit_q[0], 32'hC0FFEE12);
      check("b2b_second", commit_q[1], 32'h3456789A);
    end

    // Asynchronous reset after beat 4, between clock edges.
    send_frame(32'h12340000, 4, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("arst_table", coeff_table, 32'h0);
    check("arst_valid", 32'(table_valid), 32'd0);
    check("arst_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    b_done = n_done;
    send_frame(32'h9ABCDEF0, 8, 1'b1);
    idle(3);
    check("arst_reload", coeff_table, 32'h9ABCDEF0);
    check("arst_reload_done", 32'(n_done - b_done), 32'd1);

    // Random s_valid gaps inside a frame.
    for (int i = 0; i < NB; i++) begin
      rand_gap();
      send_beat(4'(i + 1), i == NB - 1);
    end
    idle(3);
    check("gap_table", coeff_table, 32'h12345678);

    // Randomized stream against the frame model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    commit_q.delete();
    m_cur.delete(); m_commits.delete();
    m_drain = 1'b0; m_short = 0; m_long = 0;
    b_short = n_short; b_long = n_long;
    for (int f = 0; f < 40; f++) begin
      int len;
      bit hl;
      len = $urandom_range(1, 11);
      if ($urandom_range(0, 2) == 0) len = NB;
      hl = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < len; i++) begin
        logic [3:0] d;
        logic l;
        d = 4'($urandom);
        l = hl && (i == len - 1);
        model_beat(d, l);
        rand_gap();
        send_beat(d, l);
      end
    end
    idle(4);
    check("rnd_commits", 32'(commit_q.size()), 32'(m_commits.size()));
    for (int k = 0; k < m_commits.size() && k < commit_q.size(); k++)
      check($sformatf("rnd_commit%0d", k), commit_q[k], m_commits[k]);
    check("rnd_short", 32'(n_short - b_short), 32'(m_short));
    check("rnd_long", 32'(n_long - b_long), 32'(m_long));
    exp_tab = (m_commits.size() > 0) ? m_commits[m_commits.size() - 1] : 32'h0;
    check("rnd_table", coeff_table, exp_tab);
    check("rnd_valid", 32'(table_valid), 32'(m_commits.size() > 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
